countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Count-down counterpart to the stopwatch: loads a preset time (SS.hh, 00.00–99.99) and decrements it in 0.01 s steps to 00.00, then flags expiry.
- Consumes the existing 100 Hz single-cycle tick from the clock divider and two raw active-low push-buttons.
- Drives four BCD digits; the top level feeds these into the existing seven-segment decoders on HEX5..HEX2, with the DP on HEX4.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz; benches use 4).
- CNT_W, 19, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- tick_100Hz  in  1  one-cycle enable pulse at 100 Hz from the divider
- key_startstop_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50
- key_load_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50
- preset_bcd  in  16  {tens, ones, tenths, hundredths} BCD, sampled only on a load event
- bcd_out  out  16  current count, same digit order as preset_bcd
- running  out  1  high while in RUN
- expired  out  1  high while in EXPIRED

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, bcd_out = 0000, running = 0, expired = 0.
  - Debounced key levels = 1 (released); debounce counters = 0.
- Key path (one per key):
  - 2-FF synchronizer, then debounce.
  - The counter resets whenever the synchronized level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level.
  - Press event = one-cycle pulse on a debounced 1->0 transition. Release produces no event.
  - Bounces shorter than DEBOUNCE_CYCLES produce no event.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Load event:
  - Accepted in IDLE, PAUSE and EXPIRED; ignored in RUN.
  - bcd_out <= preset_bcd, with any digit > 9 clamped to 9.
  - Next state is IDLE in all three cases (from EXPIRED this clears expired).
- Start/stop event:
  - IDLE -> RUN only if bcd_out != 0000; otherwise ignored.
  - RUN -> PAUSE.
  - PAUSE -> RUN (count is nonzero by construction).
  - Ignored in EXPIRED.
- Decrement:
  - Occurs only in RUN on a tick_100Hz cycle with no start/stop event.
  - BCD borrow chain: hundredths decrements; a digit at 0 wraps to 9 and borrows from the next digit up.
  - Example: 10.00 -> 09.99.
- Expiry:
  - If a decrement yields 0000, the same edge sets bcd_out = 0000 and state = EXPIRED.
  - The count holds at 0000; it never wraps to 99.99.
- Simultaneous events:
  - Start/stop and tick in RUN: pause wins, no decrement.
  - Start/stop and tick in PAUSE: resume, no decrement on that cycle.
  - Load and start/stop in IDLE/PAUSE/EXPIRED: load wins, start/stop is dropped.
  - Load and start/stop in RUN: pause taken, load dropped.
- Outputs are registered: running = (state == RUN), expired = (state == EXPIRED).
- Timing:
  - FSM/count changes appear on the edge after the event pulse.
  - Key-to-event latency = 2 sync cycles + DEBOUNCE_CYCLES + 1.
- A reset mid-RUN returns to the reset values immediately; no partial decrement survives.

Decomposition:
- Package countdown_pkg holds:
  - state enum (IDLE, RUN, PAUSE, EXPIRED);
  - BCD_DIGIT_W = 4, BCD_MAX = 9, NUM_DIGITS = 4;
  - function bcd_clamp(digit).
- Sub-module key_debounce (synchronizer + debounce + press-event pulse), instantiated twice.
- Top-level integration (new file, not part of this block) reuses the clock divider and seven-segment decoder unchanged.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES = 4.)
1. Reset mid-count: assert reset while in RUN at 12.34 -> bcd_out = 0000, running = 0, expired = 0 immediately; IDLE after release.
2. Load + run: preset 00.05, load press, start press, 5 ticks -> bcd_out steps 0005, 0004, 0003, 0002, 0001, 0000. expired = 1 on the 5th tick edge; further ticks keep 0000.
3. Borrow chain: load 10.00, run, 1 tick -> 0999. Load 00.10, run, 1 tick -> 0009.
4. Pause/resume: run from 00.50, pause after 3 ticks -> 0047. 10 ticks while paused -> 0047 held. Resume and start/stop coincident with a tick -> still 0047; next tick -> 0046.
5. Debounce and edge cases:
   - Glitch low for 3 cycles -> no event.
   - Held low for 10 cycles -> exactly one event, none on release.
   - Start press with count 0000 -> stays IDLE.
   - Preset 0xFA5C -> loads 9959.
6. Event arbitration:
   - Load and start/stop in the same cycle in PAUSE -> new preset loaded, state IDLE.
   - Load during RUN -> ignored, count keeps decrementing.
   - Load in EXPIRED -> expired = 0, state IDLE.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the countdown timer.
// State encoding, digit geometry and digit clamp/decrement functions.
package countdown_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = NUM_DIGITS * BCD_DIGIT_W;

  typedef logic [BCD_DIGIT_W-1:0] digit_t;
  typedef logic [BCD_W-1:0]       bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_e;

  localparam digit_t DIGIT_MAX = digit_t'(BCD_MAX);

  // Non-decimal nibbles saturate to 9.
  function automatic digit_t bcd_clamp(
    input digit_t digit
  );
    return (digit > DIGIT_MAX) ? DIGIT_MAX : digit;
  endfunction

  function automatic bcd_t bcd_load(
    input bcd_t v
  );
    bcd_t r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
        bcd_clamp(v[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    return r;
  endfunction

  // One-step decrement with borrow: a 0 digit
  // becomes 9 and passes the borrow upward.
  function automatic bcd_t bcd_dec(
    input bcd_t v
  );
    bcd_t   r;
    logic   borrow;
    digit_t d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      if (borrow) begin
        if (d == '0) begin
          r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = DIGIT_MAX;
        end else begin
          r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = d - 1'b1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> synchronized, debounced level -> press pulse.
// Ports: clk_i, rst_i (async high), key_n_i (raw), press_o (1-cycle).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;

  // Counter only runs while the synchronized level
  // disagrees with the accepted one.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
      press_q  <= db_dly_q & ~db_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/countdown_timer.sv
// SS.hh countdown: load preset, run/pause, 0.01 s decrement, expiry.
// Ports: clock/reset, tick, 2 raw keys, preset_bcd -> bcd_out, flags.
import countdown_pkg::*;

module countdown_timer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick_100Hz,
  input  logic        key_startstop_n,
  input  logic        key_load_n,
  input  logic [15:0] preset_bcd,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic        expired
);

  logic   ss_ev;
  logic   ld_ev;
  state_e state_q;
  state_e state_d;
  bcd_t   bcd_q;
  bcd_t   bcd_d;
  bcd_t   dec_v;
  bcd_t   load_v;
  logic   running_q;
  logic   expired_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_ss (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .key_n_i(key_startstop_n),
    .press_o(ss_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_ld (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .key_n_i(key_load_n),
    .press_o(ld_ev)
  );

  assign dec_v  = bcd_dec(bcd_q);
  assign load_v = bcd_load(preset_bcd);

  // Load beats start/stop everywhere except RUN,
  // where start/stop beats both load and tick.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_ev) begin
          bcd_d = load_v;
        end else if (ss_ev && bcd_q != '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ss_ev) begin
          state_d = ST_PAUSE;
        end else if (tick_100Hz) begin
          bcd_d = dec_v;
          if (dec_v == '0) begin
            state_d = ST_EXPIRED;
          end
        end
      end
      ST_PAUSE: begin
        if (ld_ev) begin
          bcd_d   = load_v;
          state_d = ST_IDLE;
        end else if (ss_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (ld_ev) begin
          bcd_d   = load_v;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign bcd_out = bcd_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule
